// File: rtl/seg7_pkg.sv
// Shared segment constants and the hex-to-segment decoder for the seven-segment scan driver.
// All patterns are active-low, packed as {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'b1000000;
      4'h1: pat = 7'b1111001;
      4'h2: pat = 7'b0100100;
      4'h3: pat = 7'b0110000;
      4'h4: pat = 7'b0011001;
      4'h5: pat = 7'b0010010;
      4'h6: pat = 7'b0000010;
      4'h7: pat = 7'b1111000;
      4'h8: pat = 7'b0000000;
      4'h9: pat = 7'b0010000;
      4'hA: pat = 7'b0001000;
      4'hB: pat = 7'b0000011;
      4'hC: pat = 7'b1000110;
      4'hD: pat = 7'b0100001;
      4'hE: pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_digit_select.sv
// Combinational content for the currently scanned digit: hex decode, leading-zero blanking,
// minus-sign placement and the decimal point.
module seg7_digit_select
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    negative,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lzb_en,
  input  logic [IDX_W-1:0]        idx,
  output logic [6:0]              seg,
  output logic                    dp
);

  logic [NUM_DIGITS-1:0] blank;
  logic [IDX_W-1:0]      minus_pos;
  logic                  zero_run;
  logic [3:0]            nib;
  logic                  blank_sel;

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    // Walk down from the top digit; digit 0 is never part of the blanked run.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (value[4*i +: 4] == 4'h0);
      blank[i] = lzb_en && zero_run;
    end

    // The blanked run is contiguous from the top, so the last hit is its lowest position.
    minus_pos = IDX_W'(NUM_DIGITS - 1);
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (blank[i]) minus_pos = IDX_W'(i);
    end

    nib       = 4'h0;
    dp        = 1'b1;
    blank_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib       = value[4*i +: 4];
        dp        = ~dp_mask[i];
        blank_sel = blank[i];
      end
    end

    if (negative && (idx == minus_pos)) seg = SEG_MINUS;
    else if (blank_sel)                 seg = SEG_BLANK;
    else                                seg = hex_to_seg(nib);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous value update,
// anti-ghosting guard time at the start of each digit slot and whole-display blink.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD        = 500,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    negative,
  input  logic                    load,
  input  logic                    lzb_en,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blink_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] SLOT_PRE  = CNT_W'(SCAN_DIV - 2);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]        cnt_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic                    slot_end;
  logic                    frame_end;
  logic                    frame_pre;
  logic                    in_guard;

  logic [4*NUM_DIGITS-1:0] pend_val;
  logic                    pend_neg;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [4*NUM_DIGITS-1:0] shd_val;
  logic                    shd_neg;
  logic [NUM_DIGITS-1:0]   shd_dp;

  logic                    blink_on;
  logic [BLK_W-1:0]        blink_cnt;

  logic [6:0]              dsel_seg;
  logic                    dsel_dp;

  logic [6:0]              seg_p1;
  logic                    dp_p1;
  logic [NUM_DIGITS-1:0]   an_p1;
  logic                    tick_p1;

  assign slot_end  = (cnt_p0 == SLOT_LAST);
  assign frame_end = slot_end && (idx_p0 == IDX_LAST);
  assign frame_pre = (cnt_p0 == SLOT_PRE) && (idx_p0 == IDX_LAST);
  assign in_guard  = (cnt_p0 < GUARD_END);

  // ---- stage p0: scan counters, pending/shadow capture, blink phase ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0    <= '0;
      idx_p0    <= '0;
      pend_val  <= '0;
      pend_neg  <= 1'b0;
      pend_dp   <= '0;
      shd_val   <= '0;
      shd_neg   <= 1'b0;
      shd_dp    <= '0;
      blink_on  <= 1'b1;
      blink_cnt <= '0;
    end else begin
      cnt_p0 <= slot_end ? '0 : cnt_p0 + CNT_W'(1);
      if (slot_end) idx_p0 <= frame_end ? '0 : idx_p0 + IDX_W'(1);

      if (load) begin
        pend_val <= value;
        pend_neg <= negative;
        pend_dp  <= dp_mask;
      end

      if (frame_end) begin
        // A load on the boundary cycle bypasses pending so it is not delayed a whole frame.
        shd_val <= load ? value    : pend_val;
        shd_neg <= load ? negative : pend_neg;
        shd_dp  <= load ? dp_mask  : pend_dp;

        if (blink_en) begin
          if (blink_cnt == BLK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
          end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
          end
        end else begin
          blink_cnt <= '0;
          blink_on  <= 1'b1;
        end
      end
    end
  end

  seg7_digit_select #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_digit_select (
    .value   (shd_val),
    .negative(shd_neg),
    .dp_mask (shd_dp),
    .lzb_en  (lzb_en),
    .idx     (idx_p0),
    .seg     (dsel_seg),
    .dp      (dsel_dp)
  );

  // ---- stage p1: registered pin drive ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p1  <= SEG_BLANK;
      dp_p1   <= 1'b1;
      an_p1   <= '1;
      tick_p1 <= 1'b0;
    end else begin
      tick_p1 <= frame_pre;
      if (in_guard) begin
        seg_p1 <= SEG_BLANK;
        dp_p1  <= 1'b1;
        an_p1  <= '1;
      end else begin
        seg_p1 <= dsel_seg;
        dp_p1  <= dsel_dp;
        an_p1  <= blink_on ? ~(NUM_DIGITS'(1) << idx_p0) : '1;
      end
    end
  end

  assign seg        = seg_p1;
  assign dp         = dp_p1;
  assign an         = an_p1;
  assign frame_tick = tick_p1;

endmodule
